// File: rtl/uart_rx_packet_ctrl.sv
// Packet framer behind a UART receiver: sync, length, payload, XOR checksum; payload is released only once committed.
// Optional packet statistics counters are enabled with `define UART_RX_PKT_STATS_EN.
module uart_rx_packet_ctrl #(
  parameter int                WIDTH          = 8,
  parameter int                DEPTH          = 16,
  parameter int                MAX_LEN        = 16,
  parameter logic [WIDTH-1:0]  SYNC_BYTE      = 8'hA5,
  parameter int                TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           rx_data,
  input  logic                       rx_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       pkt_done,
  output logic                       pkt_err,
  output logic [1:0]                 err_code,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
`ifdef UART_RX_PKT_STATS_EN
  ,
  output logic [15:0]                good_cnt,
  output logic [15:0]                err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CHECK   = 2'd3;

  localparam logic [1:0] ERR_CHK     = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_OVF     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  logic [WIDTH:0]   mem [DEPTH];
  logic [1:0]       state;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    commit_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] chk_q;
  logic [TW-1:0]    to_cnt;

  logic [PW-1:0]    used;
  logic [PW-1:0]    free_cnt;
  logic             len_bad;
  logic             len_ovf;
  logic             last_byte;
  logic             rd_fire;
  logic             timeout_hit;
  logic [WIDTH:0]   head;

  // Free space counts staged bytes too, so a packet can never overrun unread data.
  assign used        = wr_ptr - rd_ptr;
  assign free_cnt    = DEPTH_P - used;
  assign len_bad     = (rx_data == '0) || (32'(rx_data) > 32'(MAX_LEN));
  assign len_ovf     = 32'(rx_data) > 32'(free_cnt);
  assign last_byte   = (cnt_q == len_q - 1'b1);
  assign rd_fire     = out_valid && out_ready;
  assign timeout_hit = (state != ST_IDLE) && !rx_valid && (to_cnt == TO_LAST);

  // Reader only sees committed entries; the head is forced to zero when empty.
  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_valid  = (rd_ptr != commit_ptr);
  assign out_data   = out_valid ? head[WIDTH-1:0] : '0;
  assign out_last   = out_valid ? head[WIDTH] : 1'b0;
  assign fifo_count = CW'(commit_ptr - rd_ptr);

  always_ff @(posedge clk) begin
    if (state == ST_PAYLOAD && rx_valid) begin
      mem[wr_ptr[AW-1:0]] <= {last_byte, rx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      chk_q      <= '0;
      to_cnt     <= '0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      err_code   <= ERR_CHK;
    end else begin
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;

      if (rd_fire) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      if (state == ST_IDLE || rx_valid) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end

      // A byte arriving on the expiry cycle keeps the packet alive.
      if (timeout_hit) begin
        wr_ptr   <= commit_ptr;
        pkt_err  <= 1'b1;
        err_code <= ERR_TIMEOUT;
        to_cnt   <= '0;
        state    <= ST_IDLE;
      end else if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (len_bad) begin
              pkt_err  <= 1'b1;
              err_code <= ERR_LEN;
              state    <= ST_IDLE;
            end else if (len_ovf) begin
              pkt_err  <= 1'b1;
              err_code <= ERR_OVF;
              state    <= ST_IDLE;
            end else begin
              len_q <= rx_data;
              chk_q <= rx_data;
              cnt_q <= '0;
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            wr_ptr <= wr_ptr + PW'(1);
            chk_q  <= chk_q ^ rx_data;
            cnt_q  <= cnt_q + 1'b1;
            if (last_byte) begin
              state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (rx_data == chk_q) begin
              commit_ptr <= wr_ptr;
              pkt_done   <= 1'b1;
            end else begin
              wr_ptr   <= commit_ptr;
              pkt_err  <= 1'b1;
              err_code <= ERR_CHK;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef UART_RX_PKT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      good_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (pkt_done && good_cnt != 16'hFFFF) begin
        good_cnt <= good_cnt + 16'd1;
      end
      if (pkt_err && err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Bench for uart_rx_packet_ctrl: directed packet scenarios plus randomized traffic against a queue-based packet model.
module tb_uart_rx_packet_ctrl;

  localparam int DEPTH = 4;
  localparam int MAX_LEN = 4;
  localparam int TO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       pkt_done;
  logic       pkt_err;
  logic [1:0] err_code;
  logic [2:0] fifo_count;

  uart_rx_packet_ctrl #(
    .WIDTH(8), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: committed byte queue plus the bytes of the packet being parsed.
  logic [8:0] cq[$];
  logic [7:0] pq[$];
  bit         in_pkt = 0;
  int         idle = 0;
  bit         exp_done = 0;
  bit         exp_err = 0;
  logic [1:0] exp_code = 0;
  bit         started = 0;
  int         cyc = 0;
  int         last_byte_cyc = 0;

  always @(posedge clk) begin
    int n0;
    bit rd;
    int len;
    logic [7:0] x;
    cyc++;
    exp_done = 0;
    exp_err = 0;
    if (reset) begin
      started = 1;
      cq.delete();
      pq.delete();
      in_pkt = 0;
      idle = 0;
      exp_code = 0;
    end else begin
      n0 = cq.size();
      rd = (n0 > 0) && out_ready;
      if (rx_valid) begin
        idle = 0;
        last_byte_cyc = cyc;
        if (!in_pkt) begin
          if (rx_data == 8'hA5) begin
            in_pkt = 1;
            pq.delete();
          end
        end else begin
          pq.push_back(rx_data);
          len = int'(pq[0]);
          if (pq.size() == 1) begin
            if (len == 0 || len > MAX_LEN) begin
              exp_err = 1; exp_code = 1; in_pkt = 0;
            end else if (len > DEPTH - n0) begin
              exp_err = 1; exp_code = 2; in_pkt = 0;
            end
          end else if (pq.size() == len + 2) begin
            x = 0;
            for (int i = 0; i <= len; i++) x ^= pq[i];
            if (x == rx_data) begin
              for (int i = 1; i <= len; i++) cq.push_back({(i == len), pq[i]});
              exp_done = 1;
            end else begin
              exp_err = 1; exp_code = 0;
            end
            in_pkt = 0;
          end
        end
      end else if (in_pkt) begin
        idle++;
        if (idle == TO) begin
          exp_err = 1; exp_code = 3; in_pkt = 0; idle = 0;
        end
      end else begin
        idle = 0;
      end
      if (rd) void'(cq.pop_front());
    end
  end

  // Observation logs used by the literal scenario checks.
  int         done_seen = 0;
  logic [1:0] err_q[$];
  int         err_cyc_q[$];
  logic [8:0] got_q[$];

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", out_valid, cq.size() != 0);
      check("out_data", out_data, (cq.size() != 0) ? cq[0][7:0] : 8'h00);
      check("out_last", out_last, (cq.size() != 0) ? cq[0][8] : 1'b0);
      check("fifo_count", fifo_count, cq.size());
      check("pkt_done", pkt_done, exp_done);
      check("pkt_err", pkt_err, exp_err);
      check("err_code", err_code, exp_code);
      if (pkt_done) done_seen++;
      if (pkt_err) begin
        err_q.push_back(err_code);
        err_cyc_q.push_back(cyc);
      end
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
    end
  end

  bit rand_ready = 0;
  always @(negedge clk) if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);

  task automatic clear_logs();
    done_seen = 0;
    err_q.delete();
    err_cyc_q.delete();
    got_q.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    idle_cycles(2);
    reset = 1'b0;
  endtask

  task automatic send_pkt1();
    send_list('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}, 0);
  endtask

  task automatic check_pkt1_out(input string tag);
    check({tag, "_n"}, got_q.size(), 3);
    if (got_q.size() == 3) begin
      check({tag, "_b0"}, got_q[0], 9'h011);
      check({tag, "_b1"}, got_q[1], 9'h022);
      check({tag, "_b2"}, got_q[2], 9'h133);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b[$];
    int len, kind;
    logic [7:0] x;

    idle_cycles(3);
    reset = 1'b0;
    idle_cycles(1);
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_err_code", err_code, 0);

    // 1: good packet streams out with out_last on the final byte
    clear_logs();
    out_ready = 1'b1;
    send_pkt1();
    idle_cycles(8);
    check("t1_done", done_seen, 1);
    check("t1_errs", err_q.size(), 0);
    check_pkt1_out("t1");

    // 2: checksum mismatch
    clear_logs();
    send_list('{8'hA5, 8'h02, 8'h11, 8'h22, 8'h00}, 0);
    idle_cycles(4);
    check("t2_errs", err_q.size(), 1);
    if (err_q.size() == 1) check("t2_code", err_q[0], 0);
    check("t2_out", got_q.size(), 0);
    check("t2_count", fifo_count, 0);

    // 3: zero and oversize lengths, then recovery
    clear_logs();
    send_list('{8'hA5, 8'h00, 8'hA5, 8'h05}, 0);
    idle_cycles(2);
    check("t3_errs", err_q.size(), 2);
    if (err_q.size() == 2) begin
      check("t3_code0", err_q[0], 1);
      check("t3_code1", err_q[1], 1);
    end
    clear_logs();
    send_pkt1();
    idle_cycles(8);
    check("t3_done", done_seen, 1);
    check_pkt1_out("t3");

    // 4: inter-byte timeout fires exactly TO cycles after the last byte
    clear_logs();
    send_list('{8'hA5, 8'h02, 8'h11}, 0);
    idle_cycles(TO + 10);
    check("t4_errs", err_q.size(), 1);
    if (err_q.size() == 1) begin
      check("t4_code", err_q[0], 3);
      check("t4_delay", err_cyc_q[0] - last_byte_cyc, TO);
    end
    clear_logs();
    send_pkt1();
    idle_cycles(8);
    check("t4_done", done_seen, 1);
    check_pkt1_out("t4");

    // 5: length does not fit behind unread data
    clear_logs();
    out_ready = 1'b0;
    send_pkt1();
    idle_cycles(2);
    check("t5_count3", fifo_count, 3);
    send_list('{8'hA5, 8'h02}, 0);
    idle_cycles(2);
    check("t5_errs", err_q.size(), 1);
    if (err_q.size() == 1) check("t5_code", err_q[0], 2);
    out_ready = 1'b1;
    idle_cycles(6);
    check_pkt1_out("t5");
    check("t5_count0", fifo_count, 0);

    // 6: junk then reset mid-packet reports nothing
    clear_logs();
    send_list('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h03, 8'h11}, 0);
    do_reset();
    idle_cycles(1);
    check("t6_done", done_seen, 0);
    check("t6_errs", err_q.size(), 0);
    check("t6_valid", out_valid, 0);
    check("t6_code", err_code, 0);
    check("t6_count", fifo_count, 0);
    send_pkt1();
    idle_cycles(8);
    check("t6_done2", done_seen, 1);
    check_pkt1_out("t6");

    // Randomized traffic with random consumer backpressure
    rand_ready = 1;
    for (int p = 0; p < 300; p++) begin
      b.delete();
      kind = $urandom_range(0, 9);
      if (kind <= 4 || kind == 5) begin
        len = $urandom_range(1, MAX_LEN);
        b.push_back(8'hA5);
        b.push_back(8'(len));
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
          b.push_back(($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom));
          x ^= b[b.size() - 1];
        end
        b.push_back((kind == 5) ? ~x : x);
        send_list(b, 2);
      end else if (kind == 6) begin
        b.push_back(8'hA5);
        b.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
        send_list(b, 2);
      end else if (kind == 7) begin
        for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
        send_list(b, 3);
      end else if (kind == 8) begin
        b.push_back(8'hA5);
        b.push_back(8'($urandom_range(1, MAX_LEN)));
        send_list(b, 1);
        idle_cycles($urandom_range(TO - 2, TO + 3));
      end else begin
        if ($urandom_range(0, 3) == 0) do_reset();
        else idle_cycles($urandom_range(0, 6));
      end
    end
    rand_ready = 0;
    out_ready = 1'b1;
    idle_cycles(TO + 10);
    check("end_count", fifo_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
